// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU I/O capture path.
// Both the FIFO RTL and its bench pull their sizes from here.
package cpu_io_pkg;

    localparam int WIDTH              = 16;
    localparam int OUT_FIFO_DEPTH     = 8;
    localparam int OUT_FIFO_PTR_WIDTH = $clog2(OUT_FIFO_DEPTH);

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/cpu_out_fifo_mem.sv
// Storage array for the CPU output FIFO.
// It has one synchronous write port and one asynchronous read port, and no reset.
module cpu_out_fifo_mem #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int PTRWIDTH = 3
) (
    input  logic                clock,
    input  logic                wr_en,
    input  logic [PTRWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [PTRWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]    rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_out_fifo.sv
// First-word-fall-through capture FIFO for the CPU result port.
// It counts and flags words that arrive while the FIFO is full.
module cpu_out_fifo
    import cpu_io_pkg::*;
#(
    parameter int WIDTH     = cpu_io_pkg::WIDTH,
    parameter int DEPTH     = OUT_FIFO_DEPTH,
    parameter int PTRWIDTH  = $clog2(DEPTH),
    parameter int DROPWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 outFlag,
    input  logic [WIDTH-1:0]     out,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [WIDTH-1:0]     rd_data,
    output logic [PTRWIDTH:0]    count,
    output logic                 full,
    output logic                 empty,
    input  logic                 clear_ovf,
    output logic                 overflow,
    output logic [DROPWIDTH-1:0] drop_count
);

    localparam logic [PTRWIDTH:0] FULL_COUNT = (PTRWIDTH+1)'(DEPTH);

    logic [PTRWIDTH-1:0] wr_ptr;
    logic [PTRWIDTH-1:0] rd_ptr;
    logic [PTRWIDTH:0]   count_q;
    logic [WIDTH-1:0]    mem_data;
    logic                push;
    logic                pop;
    logic                drop;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign count    = count_q;

    // A pop frees the slot at the same edge, so a full FIFO can still accept a word then.
    assign pop  = rd_valid && rd_ready;
    assign push = outFlag && (!full || pop);
    assign drop = outFlag && full && !pop;

    assign rd_data = empty ? '0 : mem_data;

    cpu_out_fifo_mem #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PTRWIDTH(PTRWIDTH)
    ) u_mem (
        .clock  (clock),
        .wr_en  (push && !reset),
        .wr_addr(wr_ptr),
        .wr_data(out),
        .rd_addr(rd_ptr),
        .rd_data(mem_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf wins, restarting the tally at one.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_count <= DROPWIDTH'(1);
            end else if (!(&drop_count)) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_out_fifo.sv
// Scoreboard bench for cpu_out_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the FIFO.
module tb_cpu_out_fifo;
    import cpu_io_pkg::*;

    localparam int DEPTH = OUT_FIFO_DEPTH;

    logic        clock;
    logic        reset;
    logic        outFlag;
    word_t       out;
    logic        rd_ready;
    logic        rd_valid;
    word_t       rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        clear_ovf;
    logic        overflow;
    logic [7:0]  drop_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: queue contents, sticky flag and saturating drop tally.
    word_t mq[$];
    word_t sb[$];
    int    mdrop = 0;
    bit    movf  = 0;

    cpu_out_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .outFlag   (outFlag),
        .out       (out),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .clear_ovf (clear_ovf),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Status outputs against the model state that holds after the last edge.
    task automatic checkOutput();
        compare("count", int'(count), mq.size());
        compare("empty", int'(empty), int'(mq.size() == 0));
        compare("full", int'(full), int'(mq.size() == DEPTH));
        compare("rd_valid", int'(rd_valid), int'(mq.size() != 0));
        compare("overflow", int'(overflow), int'(movf));
        compare("drop_count", int'(drop_count), mdrop);
        if (mq.size() == 0) compare("rd_data_empty", int'(rd_data), 0);
        else                compare("rd_data_head", int'(rd_data), int'(mq[0]));
    endtask

    // Drive one cycle of inputs and advance the model to what the next edge should do.
    task automatic applyStimulus(input bit flag, input word_t data, input bit rdy,
                                 input bit clr, input bit rst);
        bit was_full;
        bit do_pop;
        bit do_push;
        outFlag   = flag;
        out       = data;
        rd_ready  = rdy;
        clear_ovf = clr;
        reset     = rst;
        if (rst) begin
            mq.delete();
            mdrop = 0;
            movf  = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = rdy && (mq.size() != 0);
            do_push  = flag && (!was_full || do_pop);
            if (do_pop) sb.push_back(mq.pop_front());
            if (do_push) mq.push_back(data);
            if (flag && was_full && !do_pop) begin
                movf  = 1;
                mdrop = clr ? 1 : (mdrop == 255 ? 255 : mdrop + 1);
            end else if (clr) begin
                movf  = 0;
                mdrop = 0;
            end
        end
    endtask

    task automatic cyc(input bit flag, input word_t data, input bit rdy,
                       input bit clr, input bit rst);
        @(negedge clock);
        checkOutput();
        applyStimulus(flag, data, rdy, clr, rst);
    endtask

    // Monitor: every accepted handshake must deliver the next word the model popped.
    initial begin
        word_t exp;
        forever begin
            @(negedge clock);
            #1;
            if (rd_valid && rd_ready && !reset) begin
                if (sb.size() == 0) begin
                    compare("unexpected_pop", int'(rd_data), -1);
                end else begin
                    exp = sb.pop_front();
                    compare("pop_data", int'(rd_data), int'(exp));
                end
            end
        end
    end

    initial begin
        outFlag   = 1'b0;
        out       = '0;
        rd_ready  = 1'b0;
        clear_ovf = 1'b0;
        reset     = 1'b1;

        cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 0, 0);

        // Three words, then drain in order.
        cyc(1, 16'h0011, 0, 0, 0);
        cyc(1, 16'h0022, 0, 0, 0);
        cyc(1, 16'h0033, 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);

        // Fill, drop one word, drain, then clear the flag.
        for (int i = 0; i < 8; i++) cyc(1, word_t'(16'h0100 + i), 0, 0, 0);
        cyc(1, 16'h0AAA, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 1, 0);

        // Full with a simultaneous push and pop: no drop, push lands last.
        for (int i = 0; i < 8; i++) cyc(1, word_t'(16'h0200 + i), 0, 0, 0);
        cyc(1, 16'h0BBB, 1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 16'h0, 1, 0, 0);

        // Empty with outFlag and rd_ready together: push only.
        cyc(1, 16'h0CCC, 1, 0, 0);
        cyc(0, 16'h0, 1, 0, 0);

        // Stream 20 words with rd_ready toggling; stall rather than overrun.
        begin
            int sent = 0;
            int guard = 0;
            bit rdy;
            while (sent < 20 && guard < 200) begin
                rdy = guard[0];
                if (mq.size() < DEPTH || (rdy && mq.size() != 0)) begin
                    cyc(1, word_t'(16'h0300 + sent), rdy, 0, 0);
                    sent++;
                end else begin
                    cyc(0, 16'h0, rdy, 0, 0);
                end
                guard++;
            end
            compare("stream_sent", sent, 20);
        end
        for (int i = 0; i < 10; i++) cyc(0, 16'h0, 1, 0, 0);

        // Saturate the drop counter, then clear together with one more drop.
        for (int i = 0; i < 8; i++) cyc(1, word_t'(16'h0400 + i), 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, word_t'($urandom_range(0, 65535)), 0, 0, 0);
        cyc(1, 16'h0DDD, 0, 1, 0);
        cyc(0, 16'h0, 0, 1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 16'h0, 1, 0, 0);

        // Reset mid-stream with five words queued and a word pending.
        for (int i = 0; i < 5; i++) cyc(1, word_t'(16'h0500 + i), 0, 0, 0);
        cyc(1, 16'h0EEE, 1, 0, 1);
        cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc(bit'($urandom_range(0, 1)), word_t'($urandom_range(0, 65535)),
                bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 10; i++) cyc(0, 16'h0, 1, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        @(negedge clock);
        compare("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
